// File: rtl/conv_row_scheduler.sv
// Row/column sequencer for one padded convolution pass: walks virtual rows (pad + real),
// fetches each real row via req/ack, then streams IMG_W column indices via valid/ready.
module conv_row_scheduler #(
   parameter int IMG_H = 640,
   parameter int IMG_W = 640,
   parameter int PAD   = 1,
   parameter int CW    = 15
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start_i,
   input  logic          row_ack_i,
   input  logic          col_ready_i,
   output logic          busy_o,
   output logic          row_req_o,
   output logic [CW-1:0] row_idx_o,
   output logic          row_pad_o,
   output logic          first_row_o,
   output logic          last_row_o,
   output logic          col_valid_o,
   output logic [CW-1:0] col_idx_o,
   output logic          frame_done_o
);

   localparam logic [CW-1:0] V_LAST   = CW'(IMG_H + 2*PAD - 1);
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [CW-1:0] PAD_C    = CW'(PAD);
   localparam logic [CW:0]   H_C      = (CW+1)'(IMG_H);

   typedef enum logic [1:0] {IDLE, FETCH, SCAN, DONE} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] v_q, v_d;
   logic [CW-1:0] col_q, col_d;

   // Offset of the virtual row from the first real row; a borrow means a top pad row.
   logic [CW:0] rel;
   logic        pad_row, active;

   assign rel     = {1'b0, v_q} - {1'b0, PAD_C};
   assign pad_row = rel[CW] | ({1'b0, rel[CW-1:0]} >= H_C);
   assign active  = (state_q == FETCH) || (state_q == SCAN);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         v_q     <= '0;
         col_q   <= '0;
      end else begin
         state_q <= state_d;
         v_q     <= v_d;
         col_q   <= col_d;
      end
   end

   always_comb begin
      state_d = state_q;
      v_d     = v_q;
      col_d   = col_q;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               state_d = FETCH;
               v_d     = '0;
               col_d   = '0;
            end
         end
         FETCH: begin
            // Pad rows need no memory traffic and always advance after one cycle.
            if (pad_row || row_ack_i) state_d = SCAN;
         end
         SCAN: begin
            if (col_ready_i) begin
               if (col_q == COL_LAST) begin
                  col_d = '0;
                  if (v_q == V_LAST) begin
                     state_d = DONE;
                     v_d     = '0;
                  end else begin
                     state_d = FETCH;
                     v_d     = v_q + CW'(1);
                  end
               end else begin
                  col_d = col_q + CW'(1);
               end
            end
         end
         DONE: begin
            state_d = IDLE;
            v_d     = '0;
            col_d   = '0;
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy_o       = (state_q != IDLE);
   assign row_req_o    = (state_q == FETCH) && !pad_row;
   assign row_idx_o    = (active && !pad_row) ? rel[CW-1:0] : '0;
   assign row_pad_o    = active && pad_row;
   assign first_row_o  = active && (v_q == '0);
   assign last_row_o   = active && (v_q == V_LAST);
   assign col_valid_o  = (state_q == SCAN);
   assign col_idx_o    = col_q;
   assign frame_done_o = (state_q == DONE);

endmodule

// File: tb/tb_conv_row_scheduler.sv
// Bench for conv_row_scheduler: cycle table on a 1x1 no-pad instance, plus directed and
// randomized frames on a 4x3 pad-1 instance checked against a row/column reference model.
module tb_conv_row_scheduler;
   localparam int AH = 4, AW = 3, AP = 1, ACW = 8;
   localparam int BCW = 4;
   localparam int AVLAST = AH + 2*AP - 1;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic a_start, a_ack, a_ready;
   logic a_busy, a_req, a_pad, a_first, a_last, a_cv, a_done;
   logic [ACW-1:0] a_idx, a_ci;
   logic b_start, b_ack, b_ready;
   logic b_busy, b_req, b_pad, b_first, b_last, b_cv, b_done;
   logic [BCW-1:0] b_idx, b_ci;

   conv_row_scheduler #(.IMG_H(AH), .IMG_W(AW), .PAD(AP), .CW(ACW)) dut_a (
      .clk(clk), .reset(reset), .start_i(a_start), .row_ack_i(a_ack), .col_ready_i(a_ready),
      .busy_o(a_busy), .row_req_o(a_req), .row_idx_o(a_idx), .row_pad_o(a_pad),
      .first_row_o(a_first), .last_row_o(a_last), .col_valid_o(a_cv), .col_idx_o(a_ci),
      .frame_done_o(a_done));

   conv_row_scheduler #(.IMG_H(1), .IMG_W(1), .PAD(0), .CW(BCW)) dut_b (
      .clk(clk), .reset(reset), .start_i(b_start), .row_ack_i(b_ack), .col_ready_i(b_ready),
      .busy_o(b_busy), .row_req_o(b_req), .row_idx_o(b_idx), .row_pad_o(b_pad),
      .first_row_o(b_first), .last_row_o(b_last), .col_valid_o(b_cv), .col_idx_o(b_ci),
      .frame_done_o(b_done));

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   // One frame on instance A. mode: 0 tied high, 1 ack after 4 req cycles, 2 ready toggling,
   // 3 random, 4 like 1 with stray start/ack. rst_v>=0 asserts reset while scanning that row.
   task automatic run_a(input int mode, input int rst_v, input int exp_cyc, input string tag);
      int  mv, mc, xf, reqcnt, done_k;
      bit  fetched, done_next, prev_stall, prev_wait, fin, pad;
      mv = 0; mc = 0; xf = 0; reqcnt = 0; done_k = -1;
      fetched = 0; done_next = 0; prev_stall = 0; prev_wait = 0; fin = 0;
      @(negedge clk);
      a_start = 1'b1; a_ack = 1'b0; a_ready = 1'b0;
      for (int k = 1; k <= 400 && !fin; k++) begin
         @(negedge clk);
         a_start = 1'b0;
         if (done_next) begin
            chk({tag, " done"}, a_done, 1);
            chk({tag, " done_busy"}, a_busy, 1);
            chk({tag, " done_quiet"}, {a_req, a_cv, a_pad, a_first, a_last}, 0);
            done_k = k;
            fin = 1;
         end else begin
            pad = (mv < AP) || (mv >= AH + AP);
            chk({tag, " busy"}, a_busy, 1);
            chk({tag, " early_done"}, a_done, 0);
            chk({tag, " row_pad"}, a_pad, pad);
            chk({tag, " first_row"}, a_first, mv == 0);
            chk({tag, " last_row"}, a_last, mv == AVLAST);
            chk({tag, " row_idx"}, a_idx, pad ? 0 : mv - AP);
            if (k == 1) chk({tag, " first_cycle_fetch"}, {a_req, a_cv}, 0);
            if (a_req) chk({tag, " req_legal"}, {pad, fetched, a_cv}, 0);
            if (a_cv) begin
               chk({tag, " cv_after_fetch"}, fetched | pad, 1);
               chk({tag, " col_idx"}, a_ci, mc);
            end
            if (prev_stall) chk({tag, " stall_hold"}, a_cv, 1);
            if (prev_wait) chk({tag, " req_hold"}, a_req, 1);
            if (rst_v >= 0 && mv == rst_v && a_cv) begin
               #1 reset = 1'b1;
               #1 chk({tag, " async_reset"},
                      {a_busy, a_req, a_pad, a_first, a_last, a_cv, a_done, a_idx, a_ci}, 0);
               a_ack = 1'b0; a_ready = 1'b0;
               @(posedge clk);
               @(negedge clk);
               chk({tag, " held_reset"},
                   {a_busy, a_req, a_pad, a_first, a_last, a_cv, a_done, a_idx, a_ci}, 0);
               reset = 1'b0;
               fin = 1;
            end else begin
               reqcnt = a_req ? reqcnt + 1 : 0;
               case (mode)
                  0: begin a_ack = 1'b1; a_ready = 1'b1; end
                  1: begin a_ack = (reqcnt == 4); a_ready = 1'b1; end
                  2: begin a_ack = 1'b1; a_ready = (k % 2 == 1); end
                  3: begin
                     a_ack   = ($urandom % 3 == 0);
                     a_ready = ($urandom % 2 == 0);
                     a_start = ($urandom % 4 == 0);
                  end
                  default: begin
                     a_ack   = (reqcnt == 4) || !a_req;
                     a_ready = 1'b1;
                     a_start = (k % 5 == 0);
                  end
               endcase
               if (a_req && a_ack) fetched = 1;
               prev_wait  = a_req && !a_ack;
               prev_stall = a_cv && !a_ready;
               if (a_cv && a_ready) begin
                  xf++;
                  if (mc == AW - 1) begin
                     mc = 0;
                     if (mv == AVLAST) done_next = 1;
                     else begin mv++; fetched = 0; end
                  end else mc++;
               end
            end
         end
      end
      a_start = 1'b0; a_ack = 1'b0; a_ready = 1'b0;
      chk({tag, " finished"}, fin, 1);
      if (rst_v < 0) begin
         chk({tag, " transfers"}, xf, (AH + 2*AP) * AW);
         if (exp_cyc >= 0) chk({tag, " frame_cycles"}, done_k, exp_cyc);
         @(negedge clk);
         chk({tag, " idle_after"}, {a_busy, a_done, a_req, a_cv}, 0);
      end
   endtask

   typedef struct packed {
      logic       st, ak, rd;
      logic [6:0] exp;   // {busy,row_req,row_pad,first,last,col_valid,frame_done}
   } vec_t;

   initial begin
      vec_t tbl[12];
      a_start = 0; a_ack = 0; a_ready = 0;
      b_start = 0; b_ack = 0; b_ready = 0;
      #2;
      chk("reset_a", {a_busy, a_req, a_pad, a_first, a_last, a_cv, a_done, a_idx, a_ci}, 0);
      chk("reset_b", {b_busy, b_req, b_pad, b_first, b_last, b_cv, b_done, b_idx, b_ci}, 0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;

      tbl[0]  = '{1'b0, 1'b0, 1'b0, 7'b0000000};
      tbl[1]  = '{1'b1, 1'b0, 1'b0, 7'b1101100};
      tbl[2]  = '{1'b0, 1'b0, 1'b1, 7'b1101100};
      tbl[3]  = '{1'b1, 1'b1, 1'b0, 7'b1001110};
      tbl[4]  = '{1'b0, 1'b1, 1'b0, 7'b1001110};
      tbl[5]  = '{1'b1, 1'b0, 1'b1, 7'b1000001};
      tbl[6]  = '{1'b0, 1'b1, 1'b1, 7'b0000000};
      tbl[7]  = '{1'b1, 1'b1, 1'b1, 7'b1101100};
      tbl[8]  = '{1'b0, 1'b1, 1'b1, 7'b1001110};
      tbl[9]  = '{1'b0, 1'b1, 1'b1, 7'b1000001};
      tbl[10] = '{1'b1, 1'b1, 1'b1, 7'b0000000};
      tbl[11] = '{1'b0, 1'b0, 1'b0, 7'b0000000};
      for (int i = 0; i < 12; i++) begin
         b_start = tbl[i].st; b_ack = tbl[i].ak; b_ready = tbl[i].rd;
         @(negedge clk);
         chk($sformatf("b_vec%0d", i),
             {b_busy, b_req, b_pad, b_first, b_last, b_cv, b_done, b_idx, b_ci},
             {tbl[i].exp, 8'h00});
      end
      b_start = 0; b_ack = 0; b_ready = 0;

      run_a(0, -1, 25, "tied");
      run_a(1, -1, 37, "ackdly");
      run_a(2, -1, -1, "toggle");
      run_a(4, -1, 37, "stray");
      run_a(0,  2, -1, "rst");
      repeat (3) @(negedge clk);
      chk("no_restart_after_reset", {a_busy, a_done}, 0);
      run_a(0, -1, 25, "after_rst");
      for (int r = 0; r < 6; r++) run_a(3, -1, -1, $sformatf("rand%0d", r));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/conv_row_scheduler.md
# conv_row_scheduler

Sequences one padded convolution pass over an IMG_H x IMG_W feature map for the UAV YOLOv7 accelerator datapath. It walks virtual rows, including PAD zero-padding rows above and below the image. For each real row it requests a fetch from the line-buffer/memory side with a req/ack handshake, then streams IMG_W column positions to the window/MAC stage with a valid/ready handshake. It owns all row/column/padding bookkeeping so downstream stages only consume indices and flags.

## Interface
- IMG_H, 640, real image rows (>=1)
- IMG_W, 640, columns per row (>=1)
- PAD, 1, zero rows inserted above and below the image (0..3)
- CW, 15, counter/index width; must hold IMG_H+2*PAD-1 and IMG_W-1
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; forces IDLE and all outputs to reset values
- start  in  1  begin a frame; sampled only in IDLE
- row_ack  in  1  memory side accepted current row_req; ignored when row_req=0
- col_ready  in  1  downstream accepts current column
- busy  out  1  high from the cycle after start is accepted through the DONE cycle
- row_req  out  1  fetch request for real row row_idx
- row_idx  out  CW  real image row index (0..IMG_H-1); 0 on pad rows
- row_pad  out  1  current virtual row is a padding row
- first_row  out  1  current virtual row is 0
- last_row  out  1  current virtual row is IMG_H+2*PAD-1
- col_valid  out  1  col_idx valid for downstream
- col_idx  out  CW  column index 0..IMG_W-1
- frame_done  out  1  one-cycle pulse, end of frame

## Operation
- Virtual row counter v runs 0..IMG_H+2*PAD-1.
- Pad row when v<PAD or v>=IMG_H+PAD; otherwise row_idx = v-PAD.
- FSM states: IDLE, FETCH, SCAN, DONE.
- IDLE: outputs at reset values. start=1 -> FETCH with v=0, col_idx=0.
- FETCH, real row: row_req=1. Stay in FETCH until row_ack=1 is sampled, then go to SCAN. row_idx holds stable while row_req=1.
- FETCH, pad row: row_req=0. Exactly one cycle, then SCAN.
- SCAN: col_valid=1. Transfer occurs when col_valid & col_ready.
  - Transfer with col_idx<IMG_W-1: col_idx+1.
  - Transfer with col_idx=IMG_W-1, v<last: col_idx=0, v+1, go to FETCH.
  - Transfer with col_idx=IMG_W-1, v=last: go to DONE.
- DONE: frame_done=1, busy=1 for one cycle, then IDLE with v and col_idx cleared.
- row_pad, first_row and last_row are valid and stable throughout FETCH and SCAN of the row; all are 0 in IDLE and DONE.
- start while busy: ignored, no restart or queueing.
- row_ack while row_req=0 (including pad FETCH and SCAN): ignored.
- col_ready while col_valid=0: ignored.
- PAD=0: no pad rows; first_row and last_row still mark virtual rows 0 and IMG_H-1.
- IMG_W=1: each SCAN lasts one transfer. IMG_H=1: single real row between pads.
- Reset mid-frame: immediate return to IDLE, no frame_done pulse. A new start is required afterwards.

## Timing
- Reset values: busy, row_req, row_pad, first_row, last_row, col_valid, frame_done = 0; row_idx, col_idx = 0.
- All outputs are registered or decoded from registered state only. No combinational path from row_ack or col_ready to any output.
- start sampled at edge E0: busy=1 and FETCH from cycle E0+1.
- row_ack=1 in the first FETCH cycle: SCAN begins the next cycle. Minimum real-row overhead is 1 cycle; pad rows always cost exactly 1 FETCH cycle.
- Row cost with no stalls: 1 + IMG_W cycles. Frame cost: (IMG_H+2*PAD)*(1+IMG_W) cycles, plus 1 DONE cycle.
- col_ready low: col_idx, col_valid and all row flags hold.

## Test plan
- IMG_H=4, IMG_W=3, PAD=1; row_ack and col_ready tied high; start pulsed -> frame_done single pulse at cycle 25 after E0. row_pad=1 for v=0 and v=5. row_idx sequence 0,1,2,3 on real rows. 18 column transfers total. No row_req on pad rows.
- Same configuration, row_ack delayed 3 cycles on every real row -> row_req held 4 cycles per real row with row_idx stable. frame_done at cycle 37.
- col_ready toggled 1,0,1,0 throughout -> col_idx never skips or repeats. Exactly 3 transfers per row. Flags stable during stalls.
- start pulsed again mid-frame, and row_ack pulsed while row_req=0 -> no effect on sequence or timing of the frame.
- reset asserted during SCAN of v=2 -> all outputs 0 in the same cycle, no frame_done. A following start runs a full correct frame from v=0.
- PAD=0, IMG_H=1, IMG_W=1 -> one FETCH with row_req/row_idx=0, one transfer with first_row=last_row=1, then frame_done at cycle 3.
